// File: rtl/tick_pkg.sv
// Shared types and constants for the multi-channel tick generator.
// Purpose: channel state and mode encodings, plus the reset-time period.
// Ports: none (package).
package tick_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } tick_state_t;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } tick_mode_t;

    localparam int unsigned DEFAULT_PERIOD_C = 10_000_000;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, programmable period, periodic/one-shot mode
// and a two-state run/done state machine.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   active       - global enable ANDed with this channel's enable
//   sync         - zero the counter this edge (mode/state/done untouched)
//   load         - apply a new configuration this edge (wins over sync)
//   load_period  - new period; 0 is treated as 1
//   load_mode    - new periodic/one-shot mode
//   tic          - registered single-cycle pulse on counter wrap
//   done         - level, high while a fired one-shot channel sits idle
module tick_channel
    import tick_pkg::*;
#(
    parameter int          N              = 29,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic         sync,
    input  logic         load,
    input  logic [N-1:0] load_period,
    input  tick_mode_t   load_mode,
    output logic         tic,
    output logic         done
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] count, count_next;
    logic [N-1:0] period, period_next;
    logic [N-1:0] period_last;
    tick_mode_t   mode, mode_next;
    tick_state_t  state, state_next;
    logic         tic_next;

    // Period is never 0, so period-1 cannot underflow and the count
    // never exceeds it.
    assign period_last = period - ONE;

    // Next-state logic. A load restarts the channel from zero under the
    // new settings; sync zeroes the count and suppresses any wrap that
    // would have happened on the same edge.
    always_comb begin
        count_next  = count;
        period_next = period;
        mode_next   = mode;
        state_next  = state;
        tic_next    = 1'b0;
        if (load) begin
            period_next = (load_period == '0) ? ONE : load_period;
            mode_next   = load_mode;
            count_next  = '0;
            state_next  = ST_RUN;
        end else if (sync) begin
            count_next = '0;
        end else if (active && state == ST_RUN) begin
            if (count == period_last) begin
                count_next = '0;
                tic_next   = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    state_next = ST_DONE;
                end
            end else begin
                count_next = count + ONE;
            end
        end
    end

    // State register with synchronous reset back to the default period.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            period <= N'(DEFAULT_PERIOD);
            mode   <= MODE_PERIODIC;
            state  <= ST_RUN;
            tic    <= 1'b0;
        end else begin
            count  <= count_next;
            period <= period_next;
            mode   <= mode_next;
            state  <= state_next;
            tic    <= tic_next;
        end
    end

    assign done = (state == ST_DONE);

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator.
// Purpose: CH independent tick channels, each with a runtime period and
// periodic/one-shot mode written through a valid/ready config port.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   en, ch_en    - global and per-channel count enables
//   sync_all     - zero every channel counter this edge
//   cfg_valid/cfg_ready, cfg_ch, cfg_period, cfg_oneshot - config port
//   cfg_err      - one-cycle pulse when the accepted channel index is invalid
//   tic          - per-channel registered tick pulses
//   done         - per-channel one-shot finished level
module tick_gen_multi
    import tick_pkg::*;
#(
    parameter int          N              = 29,
    parameter int          CH             = 4,
    parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C,
    localparam int         CW             = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CH-1:0] ch_en,
    input  logic          sync_all,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [N-1:0]  cfg_period,
    input  logic          cfg_oneshot,
    output logic          cfg_err,
    output logic [CH-1:0] tic,
    output logic [CH-1:0] done
);

    localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CH);

    logic          accept;
    logic          apply;
    logic [CW-1:0] hold_ch;
    logic [N-1:0]  hold_period;
    tick_mode_t    hold_mode;

    assign accept = cfg_valid && cfg_ready;
    // The cycle after an accepted request is the apply cycle; ready is low
    // exactly then, so it doubles as the pending flag.
    assign apply  = !cfg_ready;

    // Config holding register. Ready drops for one cycle after each
    // transfer, limiting writes to one per two cycles. The error flag is
    // registered at the transfer so it shows up during the apply cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            hold_ch     <= '0;
            hold_period <= '0;
            hold_mode   <= MODE_PERIODIC;
        end else begin
            cfg_ready <= !accept;
            cfg_err   <= accept && ({1'b0, cfg_ch} >= CH_LIMIT);
            if (accept) begin
                hold_ch     <= cfg_ch;
                hold_period <= cfg_period;
                hold_mode   <= cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
            end
        end
    end

    // An out-of-range index matches no channel, so a bad write changes nothing.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        tick_channel #(
            .N              (N),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .active      (en && ch_en[i]),
            .sync        (sync_all),
            .load        (apply && (hold_ch == CW'(i))),
            .load_period (hold_period),
            .load_mode   (hold_mode),
            .tic         (tic[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi (CH=3, N=8, DEFAULT_PERIOD=6).
// A small vector table covers the basic periodic case; hand-written
// sequences cover one-shot, P=0, enables, bad index, sync and reset.
module tb_tick_gen_multi;

    localparam int N  = 8;
    localparam int CH = 3;
    localparam int CW = 2;
    localparam int DP = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CH-1:0] ch_en;
    logic          sync_all;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [N-1:0]  cfg_period;
    logic          cfg_oneshot;
    logic          cfg_err;
    logic [CH-1:0] tic;
    logic [CH-1:0] done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          en;
        logic [CH-1:0] ch_en;
        logic          valid;
        logic [CW-1:0] ch;
        logic [N-1:0]  period;
        logic          oneshot;
        logic [CH-1:0] exp_tic;
        logic          exp_ready;
    } vec_t;

    vec_t vecs [14];

    tick_gen_multi #(
        .N              (N),
        .CH             (CH),
        .DEFAULT_PERIOD (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_en       (ch_en),
        .sync_all    (sync_all),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .cfg_err     (cfg_err),
        .tic         (tic),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        en          = v.en;
        ch_en       = v.ch_en;
        cfg_valid   = v.valid;
        cfg_ch      = v.ch;
        cfg_period  = v.period;
        cfg_oneshot = v.oneshot;
        sync_all    = 1'b0;
    endtask

    // Reset with a config request held high to show rst overrides it.
    task automatic resetDut();
        rst         = 1'b1;
        en          = 1'b0;
        ch_en       = '0;
        sync_all    = 1'b0;
        cfg_valid   = 1'b1;
        cfg_ch      = '0;
        cfg_period  = 8'd2;
        cfg_oneshot = 1'b0;
        tick();
        tick();
        checkOutput("reset tic", 32'(tic), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset ready", 32'(cfg_ready), 32'(1));
        checkOutput("reset err", 32'(cfg_err), 32'(0));
        rst       = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // One config transfer followed by its apply cycle; returns just after
    // the apply edge.
    task automatic cfgWrite(input logic [CW-1:0] ch, input logic [N-1:0] p,
                            input logic os, input string name);
        cfg_valid   = 1'b1;
        cfg_ch      = ch;
        cfg_period  = p;
        cfg_oneshot = os;
        tick();
        cfg_valid = 1'b0;
        checkOutput({name, " ready_apply"}, 32'(cfg_ready), 32'(0));
        checkOutput({name, " err_apply"}, 32'(cfg_err), (int'(ch) >= CH) ? 32'(1) : 32'(0));
        tick();
        checkOutput({name, " ready_after"}, 32'(cfg_ready), 32'(1));
        checkOutput({name, " err_after"}, 32'(cfg_err), 32'(0));
    endtask

    initial begin
        int n;

        // en, ch_en, valid, ch, period, oneshot, exp_tic, exp_ready
        vecs[0]  = '{1'b0, 3'b111, 1'b1, 2'd0, 8'd4, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 3'b111, 1'b1, 2'd1, 8'd2, 1'b0, 3'b000, 1'b1};
        vecs[2]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[3]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[4]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 1'b1};
        vecs[6]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b110, 1'b1};
        vecs[7]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[8]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[9]  = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 1'b1};
        vecs[10] = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[11] = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b000, 1'b1};
        vecs[12] = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b110, 1'b1};
        vecs[13] = '{1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0, 3'b001, 1'b1};

        // Periodic ch0 at P=4 against ch1/ch2 at the default P=6; the
        // write attempted while ready is low must be ignored.
        resetDut();
        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput($sformatf("vec%0d tic", k), 32'(tic), 32'(vecs[k].exp_tic));
            checkOutput($sformatf("vec%0d ready", k), 32'(cfg_ready), 32'(vecs[k].exp_ready));
        end

        // One-shot ch1 at P=3, then rewrite as periodic.
        resetDut();
        en    = 1'b1;
        ch_en = 3'b010;
        cfgWrite(2'd1, 8'd3, 1'b1, "oneshot");
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("oneshot tic c%0d", i), 32'(tic), (i == 3) ? 32'(3'b010) : 32'(0));
            checkOutput($sformatf("oneshot done c%0d", i), 32'(done), (i == 3) ? 32'(3'b010) : 32'(0));
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tic != '0) n++;
        end
        checkOutput("oneshot idle tics", 32'(n), 32'(0));
        checkOutput("oneshot idle done", 32'(done), 32'(3'b010));
        cfgWrite(2'd1, 8'd3, 1'b0, "rewrite");
        checkOutput("rewrite done cleared", 32'(done), 32'(0));
        for (int i = 1; i <= 6; i++) begin
            tick();
            checkOutput($sformatf("rewrite tic c%0d", i), 32'(tic), (i % 3 == 0) ? 32'(3'b010) : 32'(0));
        end

        // Period 0 behaves as 1; channel enable and global enable hold state.
        resetDut();
        en    = 1'b1;
        ch_en = 3'b100;
        cfgWrite(2'd2, 8'd0, 1'b0, "p0");
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("p0 tic c%0d", i), 32'(tic), 32'(3'b100));
        end
        ch_en = 3'b000;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tic != '0) n++;
        end
        checkOutput("p0 disabled tics", 32'(n), 32'(0));
        ch_en = 3'b100;
        tick();
        checkOutput("p0 reenable tic", 32'(tic), 32'(3'b100));
        cfgWrite(2'd2, 8'd3, 1'b0, "p3");
        checkOutput("p3 apply tic", 32'(tic), 32'(0));
        tick();
        checkOutput("p3 first count", 32'(tic), 32'(0));
        en = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tic != '0) n++;
        end
        checkOutput("p3 en-off tics", 32'(n), 32'(0));
        en = 1'b1;
        tick();
        checkOutput("p3 resume c2", 32'(tic), 32'(0));
        tick();
        checkOutput("p3 resume wrap", 32'(tic), 32'(3'b100));

        // Out-of-range index leaves every channel's period and phase alone.
        resetDut();
        en    = 1'b1;
        ch_en = 3'b111;
        cfgWrite(2'd0, 8'd5, 1'b0, "ch0p5");
        tick();
        tick();
        cfgWrite(2'd3, 8'd7, 1'b0, "badch");
        checkOutput("badch default wrap", 32'(tic), 32'(3'b110));
        tick();
        checkOutput("badch ch0 wrap", 32'(tic), 32'(3'b001));
        for (int j = 1; j <= 5; j++) begin
            tick();
            checkOutput($sformatf("badch phase c%0d", j), 32'(tic), (j == 5) ? 32'(3'b111) : 32'(0));
        end

        // sync_all realigns ch0 (P=5) and ch1 (P=7); sync on a wrap edge
        // swallows the tick.
        resetDut();
        ch_en = 3'b011;
        cfgWrite(2'd0, 8'd5, 1'b0, "sync ch0");
        cfgWrite(2'd1, 8'd7, 1'b0, "sync ch1");
        en = 1'b1;
        tick();
        tick();
        tick();
        sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
        checkOutput("sync edge tic", 32'(tic), 32'(0));
        for (int j = 1; j <= 9; j++) begin
            tick();
            checkOutput($sformatf("sync phase c%0d", j), 32'(tic),
                        32'({1'b0, (j == 7), (j == 5)}));
        end
        sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
        checkOutput("sync on wrap tic", 32'(tic), 32'(0));
        for (int j = 1; j <= 5; j++) begin
            tick();
            checkOutput($sformatf("sync wrap c%0d", j), 32'(tic), (j == 5) ? 32'(3'b001) : 32'(0));
        end

        // Reset during an apply cycle discards the pending write and
        // restores the default period.
        cfg_valid   = 1'b1;
        cfg_ch      = 2'd0;
        cfg_period  = 8'd2;
        cfg_oneshot = 1'b0;
        tick();
        checkOutput("rst-apply ready", 32'(cfg_ready), 32'(0));
        rst = 1'b1;
        tick();
        checkOutput("rst-apply tic", 32'(tic), 32'(0));
        checkOutput("rst-apply done", 32'(done), 32'(0));
        checkOutput("rst-apply ready1", 32'(cfg_ready), 32'(1));
        checkOutput("rst-apply err", 32'(cfg_err), 32'(0));
        rst       = 1'b0;
        cfg_valid = 1'b0;
        en        = 1'b1;
        ch_en     = 3'b001;
        for (int j = 1; j <= 6; j++) begin
            tick();
            checkOutput($sformatf("post-rst default c%0d", j), 32'(tic), (j == DP) ? 32'(3'b001) : 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Multi-channel programmable tick generator; parametrised successor of the single fixed-rate tic counter.
- Each channel has its own runtime-programmable period and periodic/one-shot mode, loaded through a valid/ready config port. Channels emit single-cycle tic pulses for display refresh, animation stepping and debounce timing.
- A global sync input phase-aligns all channels.

Parameters:
- N, 29, counter/period width in bits.
- CH, 4, number of independent tick channels (1..16).
- DEFAULT_PERIOD, 10_000_000, period loaded into every channel at reset; must be ≥1 and < 2^N.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; when 0, all counters hold.
- ch_en  in  CH  per-channel enable; ANDed with en.
- sync_all  in  1  zero all channel counters this edge.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config port can accept.
- cfg_ch  in  max(1,$clog2(CH))  target channel index.
- cfg_period  in  N  new period in cycles; 0 is treated as 1.
- cfg_oneshot  in  1  1 = one-shot mode, 0 = periodic.
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch ≥ CH.
- tic  out  CH  registered single-cycle pulse per channel.
- done  out  CH  level: one-shot channel has fired and is idle.

Behaviour:
- Reset (synchronous, rst=1 at edge): all counts 0; period=DEFAULT_PERIOD; mode periodic; state ST_RUN. tic=0, done=0, cfg_err=0, cfg_ready=1. rst overrides every other input.
- Channel i is active in a cycle when en & ch_en[i] & state==ST_RUN.
  - Active with count < P-1: count += 1, tic[i] <= 0.
  - Active with count == P-1: count <= 0, tic[i] <= 1 (visible the following cycle).
  - Periodic mode: channel stays in ST_RUN.
  - One-shot mode: state <= ST_DONE, done[i] <= 1.
- Inactive channel: count and state hold, tic[i] <= 0.
- Timing: with a channel continuously active from a zero count, tic is high exactly once every P cycles; the first tic appears P cycles after the first active edge. P=1 gives tic every active cycle.
- ST_DONE: count frozen at 0, tic stays 0; exits only via reconfiguration or rst.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready. The fields are captured into a holding register; cfg_ready drops to 0 for exactly the next cycle (apply cycle), then returns to 1. Maximum rate is one write per 2 cycles.
  - In the apply cycle, the target channel gets period=max(cfg_period,1), its new mode, count=0, state=ST_RUN, done=0, tic=0. The channel does not count in the apply cycle.
  - If cfg_ch ≥ CH, nothing is changed and cfg_err pulses in the apply cycle.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold it.
- sync_all=1: every channel count <= 0, tic <= 0; state, mode and done are unchanged.
- Simultaneous events:
  - sync_all with a config apply: the apply wins for its channel; sync_all applies to the rest.
  - sync_all with a wrap on the same edge: no tic.
  - rst with a pending apply: the pending apply is discarded.
- Arithmetic: unsigned N-bit; compare count == P-1, where P-1 is computed in N bits. Counts never exceed P-1, so no overflow is possible.
- Mid-count period change: the count restarts at 0 under the new period, so no truncated or stretched pulse occurs.

Decomposition:
- Package tick_pkg:
  - typedef enum logic {ST_RUN, ST_DONE} tick_state_t;
  - typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} tick_mode_t;
  - localparam DEFAULT_PERIOD_C.
- Sub-module tick_channel: holds one counter, period, mode and state; has load/sync/active inputs and tic/done outputs. It is instantiated CH times in a generate loop.
- The top level holds the config handshake register, decode and cfg_err.

Test Plan:
- Reset then en=1, all ch_en=1, default period overridden to 4 on ch0 → tic[0] at cycles 4,8,12 after the first active edge; cfg_ready low for exactly 1 cycle after the write.
- Write ch1 period=3 one-shot → single tic[1] three cycles after apply; done[1]=1 thereafter; no further tics for 20 cycles. A rewrite of ch1 in periodic mode clears done[1].
- Write period=0 to ch2 → tic[2] every active cycle. Drop ch_en[2] for 5 cycles → no tics and count held; the next tic arrives one cycle after re-enable.
- CH=3: write cfg_ch=3 → cfg_err pulses once; all channels' periods and phases are unchanged.
- Channels 0 (P=5) and 1 (P=7) running; pulse sync_all → both next tics occur 5 and 7 cycles later. sync_all coincident with a wrap → no tic that cycle.
- Assert rst mid-count and during the apply cycle → all outputs 0 next cycle; periods revert to DEFAULT_PERIOD; the pending config is discarded; cfg_ready=1.
